// File: rtl/elevator_pkg.sv
// Shared elevator constants, door/motion encodings and hall-call bit mapping.
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int HALL_W     = 14;
  localparam int CAR_W      = 9;
  localparam int CAR_OPEN   = 8;
  localparam int CAR_CLOSE  = 9;

  typedef enum logic { CLOSE = 1'b0, OPEN = 1'b1 } door_t;
  typedef enum logic { HOLD  = 1'b0, MOVE = 1'b1 } move_t;

  // Floor f owns hall bits [2f-1:2f-2]; the upper bit of the pair is the UP call.
  function automatic int hall_bit(input int floor, input logic up);
    return 2 * floor - 2 + int'(up);
  endfunction

endpackage

// File: rtl/elevator_call_panel_debounce.sv
// Single switch conditioner: 2-flop synchroniser, tick-sampled debouncer and rise pulse.
module call_debounce #(
  parameter int DEBOUNCE_SAMPLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic       syncA;
  logic       syncB;
  logic       debLevel;
  logic       armed;
  logic [3:0] count;

  // NOTE: every register here is written with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncA    <= 1'b0;
      syncB    <= 1'b0;
      debLevel <= 1'b0;
      armed    <= 1'b0;
      count    <= '0;
      rise     <= 1'b0;
    end else begin
      syncA <= raw;
      syncB <= syncA;
      rise  <= 1'b0;
      if (tick) begin
        // A switch held through reset stays inert until it has been seen released.
        if (!syncB) armed <= 1'b1;
        if (syncB != debLevel) begin
          if (count == 4'(DEBOUNCE_SAMPLES - 1)) begin
            debLevel <= syncB;
            count    <= '0;
            rise     <= syncB & armed;
          end else begin
            count <= count + 4'd1;
          end
        end else begin
          count <= '0;
        end
      end
    end
  end

  assign level = debLevel & armed;

endmodule

// File: rtl/elevator_call_panel.sv
// Hall/car pushbutton front end: debounces switches, latches masked calls and
// retires them only when the controller's returned button state clears them.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int SAMPLE_DIV       = 100000,
  parameter int DEBOUNCE_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HALL_W-1:0] raw_hall,
  input  logic [CAR_W:1]    raw_car,
  input  logic [2:0]        cur_floor,
  input  logic              door_state,
  input  logic              move,
  input  logic              fb_valid,
  input  logic [HALL_W-1:0] fb_hall,
  input  logic [CAR_W:1]    fb_car,
  output logic [HALL_W-1:0] floor_button,
  output logic [CAR_W:1]    internal_button,
  output logic              press_pulse
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [DIV_W-1:0]      divCount;
  logic                  tick;
  logic [HALL_W-1:0]     hallLevel;
  logic [HALL_W-1:0]     hallRise;
  logic [CAR_W:1]        carLevel;
  logic [CAR_W:1]        carRise;
  logic [HALL_W-1:0]     hallPress;
  logic [NUM_FLOORS:1]   carPress;
  logic [HALL_W-1:0]     hallPending;
  logic [NUM_FLOORS:1]   carPending;
  logic                  atFloor;
  logic                  unusedBits;

  always_ff @(posedge clk) begin
    if (reset) begin
      divCount <= '0;
      tick     <= 1'b0;
    end else if (divCount == DIV_W'(SAMPLE_DIV - 1)) begin
      divCount <= '0;
      tick     <= 1'b1;
    end else begin
      divCount <= divCount + 1'b1;
      tick     <= 1'b0;
    end
  end

  for (genvar i = 0; i < HALL_W; i++) begin : g_hall
    call_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (raw_hall[i]),
      .level (hallLevel[i]),
      .rise  (hallRise[i])
    );
  end

  for (genvar i = 1; i <= CAR_W; i++) begin : g_car
    call_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (raw_car[i]),
      .level (carLevel[i]),
      .rise  (carRise[i])
    );
  end

  // Floor-match masks only apply while parked with the door open on a real floor.
  assign atFloor = (cur_floor != 3'd0) && (door_state == OPEN) && (move == HOLD);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    hallPress = hallRise;
    carPress  = carRise[NUM_FLOORS:1];
    hallPress[hall_bit(1, 1'b0)]          = 1'b0;
    hallPress[hall_bit(NUM_FLOORS, 1'b1)] = 1'b0;
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (atFloor && cur_floor == 3'(f)) begin
        hallPress[hall_bit(f, 1'b0)] = 1'b0;
        hallPress[hall_bit(f, 1'b1)] = 1'b0;
        carPress[f]                  = 1'b0;
      end
    end
  end

  // Feedback can only clear pending calls; a same-cycle press always survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      hallPending <= '0;
      carPending  <= '0;
      press_pulse <= 1'b0;
    end else begin
      hallPending <= (hallPending & (fb_valid ? fb_hall : '1)) | hallPress;
      carPending  <= (carPending & (fb_valid ? fb_car[NUM_FLOORS:1] : '1)) | carPress;
      press_pulse <= (|hallPress) | (|carPress);
    end
  end

  assign floor_button    = hallPending;
  assign internal_button = {carLevel[CAR_CLOSE], carLevel[CAR_OPEN], carPending};

  assign unusedBits = &{1'b0, fb_car[CAR_CLOSE:CAR_OPEN], hallLevel,
                        carLevel[NUM_FLOORS:1], carRise[CAR_CLOSE:CAR_OPEN]};

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with a fast debounce setting.
module tb_elevator_call_panel;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] raw_hall;
  logic [9:1]  raw_car;
  logic [2:0]  cur_floor;
  logic        door_state;
  logic        move;
  logic        fb_valid;
  logic [13:0] fb_hall;
  logic [9:1]  fb_car;
  logic [13:0] floor_button;
  logic [9:1]  internal_button;
  logic        press_pulse;

  int numAsserts = 0;
  int numFails   = 0;
  int pulseCnt   = 0;

  elevator_call_panel #(.SAMPLE_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .raw_hall        (raw_hall),
    .raw_car         (raw_car),
    .cur_floor       (cur_floor),
    .door_state      (door_state),
    .move            (move),
    .fb_valid        (fb_valid),
    .fb_hall         (fb_hall),
    .fb_car          (fb_car),
    .floor_button    (floor_button),
    .internal_button (internal_button),
    .press_pulse     (press_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && press_pulse) pulseCnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numAsserts++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [13:0] orHall;
  logic [9:1]  orCar;
  int          pulseBase;
  int          found;

  initial begin
    reset      = 1'b1;
    raw_hall   = '1;
    raw_car    = '1;
    cur_floor  = 3'd1;
    door_state = 1'b0;
    move       = 1'b0;
    fb_valid   = 1'b0;
    fb_hall    = '0;
    fb_car     = '0;

    // Reset with every switch held
    step(6);
    check("reset_floor_button", 32'(floor_button), 32'h0);
    check("reset_internal_button", 32'(internal_button), 32'h0);
    check("reset_press_pulse", 32'(press_pulse), 32'h0);

    // Switches held through reset must not register
    reset  = 1'b0;
    orHall = '0;
    orCar  = '0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      orHall |= floor_button;
      orCar  |= internal_button;
    end
    check("held_after_reset_hall", 32'(orHall), 32'h0);
    check("held_after_reset_car", 32'(orCar), 32'h0);
    check("held_after_reset_pulse", 32'(pulseCnt), 32'd0);

    raw_hall = '0;
    raw_car  = '0;
    step(30);
    check("release_no_call", 32'(floor_button), 32'h0);

    // 5-cycle glitch is shorter than three sample ticks
    raw_hall[3] = 1'b1;
    step(5);
    raw_hall[3] = 1'b0;
    step(30);
    check("glitch_rejected", 32'(floor_button), 32'h0);
    check("glitch_no_pulse", 32'(pulseCnt), 32'd0);

    // Held press latches within 18 cycles
    raw_hall[3] = 1'b1;
    found = 0;
    for (int i = 0; i < 18 && found == 0; i++) begin
      step(1);
      if (floor_button[3]) found = 1;
    end
    check("hold_latch_in_time", 32'(found), 32'd1);
    step(22);
    check("hold_value", 32'(floor_button), 32'h0008);
    check("hold_one_pulse", 32'(pulseCnt), 32'd1);
    raw_hall[3] = 1'b0;
    step(20);
    check("release_keeps_call", 32'(floor_button), 32'h0008);

    // Feedback clears the hall call
    fb_valid = 1'b1;
    fb_hall  = '0;
    step(1);
    fb_valid = 1'b0;
    check("fb_clear_hall", 32'(floor_button), 32'h0);

    // Floor 1 DOWN and floor 7 UP do not exist
    pulseBase = pulseCnt;
    raw_hall[0]  = 1'b1;
    raw_hall[13] = 1'b1;
    step(30);
    check("illegal_mask", 32'(floor_button), 32'h0);
    check("illegal_no_pulse", 32'(pulseCnt - pulseBase), 32'd0);
    raw_hall = '0;
    step(20);

    // Car call for floor 5, then cleared by feedback
    raw_car[5] = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1);
      if (internal_button[5]) found = 1;
    end
    check("car5_latch", 32'(found), 32'd1);
    raw_car[5] = 1'b0;
    step(20);
    check("car5_pending", 32'(internal_button), 32'h010);
    fb_valid = 1'b1;
    fb_car   = '0;
    step(1);
    fb_valid = 1'b0;
    check("car5_cleared", 32'(internal_button), 32'h0);

    // Feedback cannot create calls
    fb_valid = 1'b1;
    fb_hall  = 14'h3FFF;
    fb_car   = '1;
    step(1);
    fb_valid = 1'b0;
    fb_hall  = '0;
    fb_car   = '0;
    check("fb_no_create_hall", 32'(floor_button), 32'h0);
    check("fb_no_create_car", 32'(internal_button), 32'h0);

    // Press coinciding with clearing feedback survives
    fb_valid    = 1'b1;
    raw_hall[6] = 1'b1;
    found = 0;
    for (int i = 0; i < 25 && found == 0; i++) begin
      step(1);
      if (press_pulse) found = 1;
    end
    check("race_pulse_seen", 32'(found), 32'd1);
    check("race_press_wins", 32'(floor_button), 32'h0040);
    fb_valid = 1'b0;
    step(1);
    check("race_stays", 32'(floor_button), 32'h0040);
    raw_hall[6] = 1'b0;
    fb_valid = 1'b1;
    step(1);
    fb_valid = 1'b0;
    check("race_cleared", 32'(floor_button), 32'h0);
    step(20);

    // Parked at floor 4, door open: floor-4 calls ignored, floor-3 car call taken
    cur_floor  = 3'd4;
    door_state = 1'b1;
    move       = 1'b0;
    pulseBase  = pulseCnt;
    raw_car[4]  = 1'b1;
    raw_car[3]  = 1'b1;
    raw_hall[7] = 1'b1;
    step(30);
    check("door_mask_hall", 32'(floor_button), 32'h0);
    check("door_mask_car", 32'(internal_button), 32'h004);
    check("door_mask_pulse", 32'(pulseCnt - pulseBase), 32'd1);
    raw_car  = '0;
    raw_hall = '0;
    step(20);

    // Door-open button is a debounced level, not latched
    raw_car[8] = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1);
      if (internal_button[8]) found = 1;
    end
    check("open_btn_high", 32'(found), 32'd1);
    check("open_btn_value", 32'(internal_button), 32'h084);
    raw_car[8] = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1);
      if (!internal_button[8]) found = 1;
    end
    check("open_btn_released", 32'(found), 32'd1);

    // Mid-operation reset drops pending calls
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    check("midreset_car", 32'(internal_button), 32'h0);
    check("midreset_hall", 32'(floor_button), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
